// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-cycle sequencing for the 5-stage core.
// Decides stage-register enables and flushes, PC load, and redirect commit.
// Tracks the wrong-path fetch discard state and keeps saturating stall and
// flush event counters.
//
// Enable/flush semantics: an enable of 1 lets a stage register capture its
// upstream data. A flush of 1 makes that register capture a bubble (valid=0)
// regardless of its enable. All enables and flushes are combinational from
// inputs and state. Only the state and the two counters are registered.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_ex_valid,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_mem_valid,
    input  logic             ex_mem_jump_flag,
    input  logic             ex_mem_branch_flag,
    input  logic             ex_mem_zero,
    input  logic             ex_mem_mem_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             redirect,
    output logic             discard,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // RUN: normal fetch. DISCARD: a wrong-path imem fetch is still
    // outstanding and its response must be dropped.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic redir_c;
    logic dstall;
    logic lu;
    logic stall_ev;
    logic flush_ev;

    // Hazard sources.
    assign redir_c = ex_mem_valid & (ex_mem_jump_flag | (ex_mem_branch_flag & ex_mem_zero));
    assign dstall  = ex_mem_valid & ex_mem_mem_req & ~dmem_ready;
    assign lu      = id_ex_valid & id_ex_mem_read & (id_ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_ex_rd == id_rs1)) |
                      (id_use_rs2 & (id_ex_rd == id_rs2)));

    // Priority decode of enables, flushes, next state and counter events.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        redirect     = 1'b0;
        state_d      = state_q;
        stall_ev     = 1'b0;
        flush_ev     = 1'b0;

        if (dstall) begin
            // Data memory wait freezes the whole pipe, including DISCARD.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            stall_ev     = 1'b1;
        end else if (redir_c) begin
            // Commit target to PC and squash the three younger stages.
            redirect     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = imem_ready ? ST_RUN : ST_DISCARD;
            flush_ev     = 1'b1;
        end else if (state_q == ST_DISCARD) begin
            // Drop the wrong-path response; target fetch starts after it.
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            if (imem_ready) begin
                state_d = ST_RUN;
            end
            stall_ev = 1'b1;
        end else if (lu) begin
            // Hold IF/ID and PC, insert one bubble into ID/EX.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_ev    = 1'b1;
        end else if (!imem_ready) begin
            // Fetch not back yet: hold PC and feed a bubble into IF/ID.
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            stall_ev    = 1'b1;
        end

        // In reset nothing advances and every stage holds a bubble.
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            redirect     = 1'b0;
        end
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_ev && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (flush_ev && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign discard   = rst_n & (state_q == ST_DISCARD);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0]       id_rs1, id_rs2, id_ex_rd;
    logic             id_use_rs1, id_use_rs2, id_ex_valid, id_ex_mem_read;
    logic             ex_mem_valid, ex_mem_jump_flag, ex_mem_branch_flag, ex_mem_zero;
    logic             ex_mem_mem_req, imem_ready, dmem_ready, cnt_clr;
    logic             pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, redirect, discard;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_use_rs1         (id_use_rs1),
        .id_use_rs2         (id_use_rs2),
        .id_ex_valid        (id_ex_valid),
        .id_ex_mem_read     (id_ex_mem_read),
        .id_ex_rd           (id_ex_rd),
        .ex_mem_valid       (ex_mem_valid),
        .ex_mem_jump_flag   (ex_mem_jump_flag),
        .ex_mem_branch_flag (ex_mem_branch_flag),
        .ex_mem_zero        (ex_mem_zero),
        .ex_mem_mem_req     (ex_mem_mem_req),
        .imem_ready         (imem_ready),
        .dmem_ready         (dmem_ready),
        .cnt_clr            (cnt_clr),
        .pc_write           (pc_write),
        .if_id_write        (if_id_write),
        .id_ex_write        (id_ex_write),
        .ex_mem_write       (ex_mem_write),
        .mem_wb_write       (mem_wb_write),
        .if_id_flush        (if_id_flush),
        .id_ex_flush        (id_ex_flush),
        .ex_mem_flush       (ex_mem_flush),
        .redirect           (redirect),
        .discard            (discard),
        .stall_cnt          (stall_cnt),
        .flush_cnt          (flush_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: whether a wrong-path fetch is pending, and
    // plain integer event counts clamped at the counter maximum.
    bit m_pending;
    int m_stall;
    int m_flush;

    task automatic model_reset();
        m_pending = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_ex_valid = 1'b0; id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
        ex_mem_valid = 1'b0; ex_mem_jump_flag = 1'b0; ex_mem_branch_flag = 1'b0;
        ex_mem_zero = 1'b0; ex_mem_mem_req = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1; cnt_clr = 1'b0;
    endtask

    task automatic set_random();
        id_rs1             = 5'($urandom_range(0, 3));
        id_rs2             = 5'($urandom_range(0, 3));
        id_ex_rd           = 5'($urandom_range(0, 3));
        id_use_rs1         = 1'($urandom_range(0, 1));
        id_use_rs2         = 1'($urandom_range(0, 1));
        id_ex_valid        = ($urandom_range(0, 3) != 0);
        id_ex_mem_read     = 1'($urandom_range(0, 1));
        ex_mem_valid       = ($urandom_range(0, 3) != 0);
        ex_mem_jump_flag   = ($urandom_range(0, 7) == 0);
        ex_mem_branch_flag = ($urandom_range(0, 3) == 0);
        ex_mem_zero        = 1'($urandom_range(0, 1));
        ex_mem_mem_req     = 1'($urandom_range(0, 1));
        imem_ready         = ($urandom_range(0, 9) > 2);
        dmem_ready         = ($urandom_range(0, 9) > 2);
        cnt_clr            = ($urandom_range(0, 63) == 0);
    endtask

    // Called just after a rising edge with inputs already applied. Checks
    // every output mid-cycle against the model, then advances the model
    // across the next rising edge.
    task automatic step();
        bit taken, dwait, hazard;
        bit e_pc, e_ifw, e_idw, e_exw, e_mww, e_iff, e_idf, e_exf, e_red;
        bit nxt_pending, stall_hit, flush_hit;
        #4;
        taken  = ex_mem_valid && (ex_mem_jump_flag || (ex_mem_branch_flag && ex_mem_zero));
        dwait  = ex_mem_valid && ex_mem_mem_req && !dmem_ready;
        hazard = id_ex_valid && id_ex_mem_read && (id_ex_rd != 0) &&
                 ((id_use_rs1 && id_ex_rd == id_rs1) || (id_use_rs2 && id_ex_rd == id_rs2));
        {e_pc, e_ifw, e_idw, e_exw, e_mww} = 5'b11111;
        {e_iff, e_idf, e_exf, e_red} = 4'b0000;
        nxt_pending = m_pending;
        stall_hit = 1'b0;
        flush_hit = 1'b0;
        if (dwait) begin
            {e_pc, e_ifw, e_idw, e_exw, e_mww} = 5'b00000;
            stall_hit = 1'b1;
        end else if (taken) begin
            e_red = 1'b1; e_iff = 1'b1; e_idf = 1'b1; e_exf = 1'b1;
            nxt_pending = !imem_ready;
            flush_hit = 1'b1;
        end else if (m_pending) begin
            e_pc = 1'b0; e_iff = 1'b1;
            nxt_pending = !imem_ready;
            stall_hit = 1'b1;
        end else if (hazard) begin
            e_pc = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
            stall_hit = 1'b1;
        end else if (!imem_ready) begin
            e_pc = 1'b0; e_iff = 1'b1;
            stall_hit = 1'b1;
        end
        if (!rst_n) begin
            {e_pc, e_ifw, e_idw, e_exw, e_mww, e_red} = 6'b000000;
            {e_iff, e_idf, e_exf} = 3'b111;
        end
        check("pc_write",     32'(pc_write),     32'(e_pc));
        check("if_id_write",  32'(if_id_write),  32'(e_ifw));
        check("id_ex_write",  32'(id_ex_write),  32'(e_idw));
        check("ex_mem_write", 32'(ex_mem_write), 32'(e_exw));
        check("mem_wb_write", 32'(mem_wb_write), 32'(e_mww));
        check("if_id_flush",  32'(if_id_flush),  32'(e_iff));
        check("id_ex_flush",  32'(id_ex_flush),  32'(e_idf));
        check("ex_mem_flush", 32'(ex_mem_flush), 32'(e_exf));
        check("redirect",     32'(redirect),     32'(e_red));
        check("discard",      32'(discard),      32'(m_pending && rst_n));
        check("stall_cnt",    32'(stall_cnt),    32'(m_stall));
        check("flush_cnt",    32'(flush_cnt),    32'(m_flush));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_pending = nxt_pending;
            if (cnt_clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (stall_hit && m_stall < CNT_MAX) m_stall++;
                if (flush_hit && m_flush < CNT_MAX) m_flush++;
            end
        end
        #1;
    endtask

    task automatic clear_counters();
        set_idle();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        set_idle();
        rst_n = 1'b0;
        #1;
        step();                       // reset-state outputs
        step();
        rst_n = 1'b1;                 // released between edges
        step();

        // Load-use: lw x5 in ID/EX, ID reads x5 -> one bubble.
        clear_counters();
        id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd5;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step();
        set_idle();                   // load moved to EX/MEM, bubble in ID/EX
        ex_mem_valid = 1'b1; ex_mem_mem_req = 1'b1;
        step();
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd0;
        id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step();                       // rd = x0: no stall
        check("lu_x0_stall_cnt", 32'(stall_cnt), 32'd1);

        // Taken branch, then not-taken.
        clear_counters();
        ex_mem_valid = 1'b1; ex_mem_branch_flag = 1'b1; ex_mem_zero = 1'b1;
        step();
        ex_mem_zero = 1'b0;
        step();
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_discard", 32'(discard), 32'd0);

        // Redirect while imem waits 3 cycles -> 3 DISCARD cycles.
        clear_counters();
        ex_mem_valid = 1'b1; ex_mem_jump_flag = 1'b1; imem_ready = 1'b0;
        step();
        set_idle(); imem_ready = 1'b0;
        step();
        step();
        imem_ready = 1'b1;
        step();
        step();
        check("disc_stall_cnt", 32'(stall_cnt), 32'd3);

        // dstall for 4 cycles over a redirect and a load-use.
        clear_counters();
        ex_mem_valid = 1'b1; ex_mem_jump_flag = 1'b1; ex_mem_mem_req = 1'b1;
        dmem_ready = 1'b0;
        id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd7;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        repeat (4) step();
        dmem_ready = 1'b1;
        step();
        check("dst_stall_cnt", 32'(stall_cnt), 32'd4);
        check("dst_flush_cnt", 32'(flush_cnt), 32'd1);

        // dstall during DISCARD freezes the state even when imem returns.
        set_idle();
        ex_mem_valid = 1'b1; ex_mem_jump_flag = 1'b1; imem_ready = 1'b0;
        step();
        set_idle();
        ex_mem_valid = 1'b1; ex_mem_mem_req = 1'b1; dmem_ready = 1'b0;
        repeat (2) step();
        set_idle();
        step();
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            set_random();
            step();
        end

        // Counter saturation via continuous data stalls.
        clear_counters();
        ex_mem_valid = 1'b1; ex_mem_mem_req = 1'b1; dmem_ready = 1'b0;
        repeat (CNT_MAX + 4) step();
        check("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        cnt_clr = 1'b1;               // clear beats a same-cycle stall
        step();
        cnt_clr = 1'b0;
        set_idle();
        step();
        check("clr_stall_cnt", 32'(stall_cnt), 32'd0);

        // Reset while in DISCARD.
        ex_mem_valid = 1'b1; ex_mem_jump_flag = 1'b1; imem_ready = 1'b0;
        step();
        set_idle(); imem_ready = 1'b0;
        step();
        check("pre_rst_discard", 32'(discard), 32'd1);
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_discard", 32'(discard), 32'd0);
        for (int i = 0; i < 200; i++) begin
            set_random();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
